// File: rtl/cpu_tick_gen_if.sv
// Handshake bundle for cpu_tick_gen: mode/button inputs, tick enable and debug outputs.
interface cpu_tick_gen_if;
  logic        run_mode;
  logic        step_btn;
  logic        tick;
  logic [15:0] tick_count;
  logic [1:0]  step_state;

  modport master (
    output run_mode,
    output step_btn,
    input  tick,
    input  tick_count,
    input  step_state
  );

  modport slave (
    input  run_mode,
    input  step_btn,
    output tick,
    output tick_count,
    output step_state
  );
endinterface

// File: rtl/cpu_tick_gen.sv
// CPU clock-enable generator: free-running divider or one tick per debounced step press.
// Define TICK_STEP_EN to compile in the synchronizer, debounce FSM and run_mode selection.
module cpu_tick_gen #(
  parameter int unsigned DIVISOR         = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input logic           clk,
  input logic           SYS_reset,
  cpu_tick_gen_if.slave bus
);

  localparam int unsigned     DivW    = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(DIVISOR - 1);

  logic [DivW-1:0] r_div_cnt;
  logic [DivW-1:0] w_div_cnt_d;
  logic            r_tick;
  logic            w_tick_d;
  logic [15:0]     r_tick_count;
  logic            w_run;
  logic            w_div_tick;
  logic            w_step_pulse;

`ifdef TICK_STEP_EN
  localparam int unsigned    DbW    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StConfirm = 2'd1,
    StHeld    = 2'd2,
    StRelease = 2'd3
  } step_state_e;

  step_state_e    r_state;
  step_state_e    w_state_d;
  logic [DbW-1:0] r_db_cnt;
  logic [DbW-1:0] w_db_cnt_d;
  logic           r_sync1;
  logic           r_btn_s;

  always_ff @(posedge clk) begin
    if (SYS_reset) begin
      r_sync1  <= 1'b0;
      r_btn_s  <= 1'b0;
      r_state  <= StIdle;
      r_db_cnt <= '0;
    end else begin
      r_sync1  <= bus.step_btn;
      r_btn_s  <= r_sync1;
      r_state  <= w_state_d;
      r_db_cnt <= w_db_cnt_d;
    end
  end

  // Step pulse fires only on the CONFIRM->HELD transition, so holding gives one tick.
  always_comb begin
    w_state_d    = r_state;
    w_db_cnt_d   = r_db_cnt;
    w_step_pulse = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_btn_s) begin
          w_state_d  = StConfirm;
          w_db_cnt_d = DbW'(1);
        end
      end
      StConfirm: begin
        if (!r_btn_s) begin
          w_state_d = StIdle;
        end else if (r_db_cnt == DbLast) begin
          w_state_d    = StHeld;
          w_step_pulse = 1'b1;
        end else begin
          w_db_cnt_d = r_db_cnt + DbW'(1);
        end
      end
      StHeld: begin
        if (!r_btn_s) begin
          w_state_d  = StRelease;
          w_db_cnt_d = DbW'(1);
        end
      end
      StRelease: begin
        if (r_btn_s) begin
          w_state_d = StHeld;
        end else if (r_db_cnt == DbLast) begin
          w_state_d = StIdle;
        end else begin
          w_db_cnt_d = r_db_cnt + DbW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_run          = bus.run_mode;
  assign bus.step_state = r_state;
`else
  logic w_unused_step;

  assign w_unused_step  = bus.run_mode ^ bus.step_btn;
  assign w_run          = 1'b1;
  assign w_step_pulse   = 1'b0;
  assign bus.step_state = 2'd0;
`endif

  // Leaving run mode clears the divider so re-entry waits a full period.
  always_comb begin
    w_div_tick  = w_run && (r_div_cnt == DivLast);
    w_div_cnt_d = (!w_run || w_div_tick) ? '0 : r_div_cnt + DivW'(1);
    w_tick_d    = w_run ? w_div_tick : w_step_pulse;
  end

  always_ff @(posedge clk) begin
    if (SYS_reset) begin
      r_div_cnt    <= '0;
      r_tick       <= 1'b0;
      r_tick_count <= '0;
    end else begin
      r_div_cnt <= w_div_cnt_d;
      r_tick    <= w_tick_d;
      if (w_tick_d) begin
        r_tick_count <= r_tick_count + 16'd1;
      end
    end
  end

  assign bus.tick       = r_tick;
  assign bus.tick_count = r_tick_count;

endmodule

// File: tb/tb_cpu_tick_gen.sv
// Directed bench for cpu_tick_gen: two instances (DIVISOR 1 and 4, DEBOUNCE_CYCLES 4).
// Step-mode checks are built when TICK_STEP_EN is defined; otherwise run_mode/step_btn are ignored.
module tb_cpu_tick_gen;

  logic        clk = 1'b0;
  logic        SYS_reset;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  cpu_tick_gen_if if1 ();
  cpu_tick_gen_if if4 ();

  cpu_tick_gen #(.DIVISOR(1), .DEBOUNCE_CYCLES(4)) u_dut1 (
    .clk       (clk),
    .SYS_reset (SYS_reset),
    .bus       (if1.slave)
  );

  cpu_tick_gen #(.DIVISOR(4), .DEBOUNCE_CYCLES(4)) u_dut4 (
    .clk       (clk),
    .SYS_reset (SYS_reset),
    .bus       (if4.slave)
  );

`ifdef TICK_STEP_EN
  // Expected step_state after edges 1..16 of the clean press/release, and 17..26 of the bounce.
  int unsigned st_press  [16] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 3, 3, 3, 0};
  int unsigned st_bounce [10] = '{0, 0, 1, 0, 1, 0, 1, 1, 1, 2};
  int unsigned btn_bounce[10] = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 1};
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    SYS_reset    = 1'b1;
    if1.run_mode = 1'b1;
    if1.step_btn = 1'b0;
    if4.run_mode = 1'b1;
    if4.step_btn = 1'b0;
    repeat (2) edge_step();
    chk("rst_tick1", 32'(if1.tick), 0);
    chk("rst_cnt1", 32'(if1.tick_count), 0);
    chk("rst_st1", 32'(if1.step_state), 0);
    chk("rst_tick4", 32'(if4.tick), 0);
    chk("rst_cnt4", 32'(if4.tick_count), 0);
    chk("rst_st4", 32'(if4.step_state), 0);

    // Free-run at DIVISOR 1 and 4.
    SYS_reset = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      edge_step();
      chk($sformatf("fr_tick1@%0d", n), 32'(if1.tick), 1);
      chk($sformatf("fr_cnt1@%0d", n), 32'(if1.tick_count), 32'(n));
      chk($sformatf("fr_tick4@%0d", n), 32'(if4.tick), (n % 4 == 0) ? 1 : 0);
      chk($sformatf("fr_cnt4@%0d", n), 32'(if4.tick_count), 32'(n / 4));
    end

    // Reset mid-period discards divider progress.
    repeat (2) edge_step();
    SYS_reset = 1'b1;
    edge_step();
    chk("mid_rst_tick4", 32'(if4.tick), 0);
    chk("mid_rst_cnt4", 32'(if4.tick_count), 0);
    chk("mid_rst_cnt1", 32'(if1.tick_count), 0);
    SYS_reset = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      edge_step();
      chk($sformatf("rr_tick4@%0d", n), 32'(if4.tick), (n == 4) ? 1 : 0);
    end
    chk("rr_cnt4", 32'(if4.tick_count), 1);

`ifdef TICK_STEP_EN
    // Mode change 1->0 on the edge that would tick, then 0->1 restarts from zero.
    for (int n = 5; n <= 7; n++) begin
      edge_step();
      chk($sformatf("mc_tick4@%0d", n), 32'(if4.tick), 0);
    end
    if4.run_mode = 1'b0;
    edge_step();
    chk("mc_off_tick4", 32'(if4.tick), 0);
    chk("mc_off_cnt4", 32'(if4.tick_count), 1);
    if4.run_mode = 1'b1;
    for (int n = 9; n <= 12; n++) begin
      edge_step();
      chk($sformatf("mc_on_tick4@%0d", n), 32'(if4.tick), (n == 12) ? 1 : 0);
    end
    chk("mc_on_cnt4", 32'(if4.tick_count), 2);

    // Clean press on edges 1..10, release from edge 11.
    SYS_reset    = 1'b1;
    if4.run_mode = 1'b0;
    edge_step();
    SYS_reset    = 1'b0;
    if4.step_btn = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      if (n == 11) if4.step_btn = 1'b0;
      edge_step();
      chk($sformatf("press_tick@%0d", n), 32'(if4.tick), (n == 6) ? 1 : 0);
      chk($sformatf("press_st@%0d", n), 32'(if4.step_state), 32'(st_press[n-1]));
    end
    chk("press_cnt", 32'(if4.tick_count), 1);

    // Bounce 1,0,1,0 then stable high: single tick DEBOUNCE_CYCLES+1 edges after edge 21.
    for (int n = 17; n <= 26; n++) begin
      if4.step_btn = btn_bounce[n-17][0];
      edge_step();
      chk($sformatf("bnc_tick@%0d", n), 32'(if4.tick), (n == 26) ? 1 : 0);
      chk($sformatf("bnc_st@%0d", n), 32'(if4.step_state), 32'(st_bounce[n-17]));
    end
    chk("bnc_cnt", 32'(if4.tick_count), 2);

    // Reset while in CONFIRM.
    SYS_reset = 1'b1;
    edge_step();
    chk("cf_rst0_tick", 32'(if4.tick), 0);
    SYS_reset = 1'b0;
    repeat (4) edge_step();
    chk("cf_pre_st", 32'(if4.step_state), 1);
    SYS_reset = 1'b1;
    edge_step();
    chk("cf_rst_tick", 32'(if4.tick), 0);
    chk("cf_rst_st", 32'(if4.step_state), 0);
    chk("cf_rst_cnt", 32'(if4.tick_count), 0);
`else
    // run_mode and step_btn are ignored: the divider keeps its period.
    if1.run_mode = 1'b0;
    if4.run_mode = 1'b0;
    for (int n = 5; n <= 16; n++) begin
      if1.step_btn = (n % 2 == 1);
      if4.step_btn = (n % 3 != 0);
      edge_step();
      chk($sformatf("ign_tick1@%0d", n), 32'(if1.tick), 1);
      chk($sformatf("ign_tick4@%0d", n), 32'(if4.tick), (n % 4 == 0) ? 1 : 0);
      chk($sformatf("ign_cnt4@%0d", n), 32'(if4.tick_count), 32'(n / 4));
      chk($sformatf("ign_st4@%0d", n), 32'(if4.step_state), 0);
    end
    if1.step_btn = 1'b0;
    if4.step_btn = 1'b0;
`endif

    // tick_count wrap at DIVISOR 1.
    SYS_reset    = 1'b1;
    if1.run_mode = 1'b1;
    edge_step();
    SYS_reset = 1'b0;
    repeat (65534) @(posedge clk);
    edge_step();
    chk("wrap_ffff", 32'(if1.tick_count), 32'h0000_ffff);
    edge_step();
    chk("wrap_zero", 32'(if1.tick_count), 0);
    chk("wrap_tick", 32'(if1.tick), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
